// File: rtl/riscv_control_unit.sv
// Main decoder for the single-cycle RV32I core: combinational decode of the
// instruction word, with side effects held off until the run flag is set.
module riscv_control_unit (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] ins,
   input  logic        br_less,
   input  logic        br_equal,
   output logic        rd_wren,
   output logic        isns_vld,
   output logic        br_un,
   output logic        opa_sel,
   output logic        opb_sel,
   output logic [3:0]  alu_op,
   output logic        mem_wren,
   output logic [1:0]  wb_sel,
   output logic        psel
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_SLL   = 4'b0010;
   localparam logic [3:0] ALU_SLT   = 4'b0011;
   localparam logic [3:0] ALU_SLTU  = 4'b0100;
   localparam logic [3:0] ALU_XOR   = 4'b0101;
   localparam logic [3:0] ALU_SRL   = 4'b0110;
   localparam logic [3:0] ALU_SRA   = 4'b0111;
   localparam logic [3:0] ALU_OR    = 4'b1000;
   localparam logic [3:0] ALU_AND   = 4'b1001;
   localparam logic [3:0] ALU_PASSB = 4'b1010;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       f7b5;
   logic       run;

   logic       d_rd_wren, d_vld, d_br_un, d_opa, d_opb, d_mem_wren, d_psel;
   logic [3:0] d_alu, alu_f3;
   logic [1:0] d_wb;

   assign opcode = ins[6:0];
   assign funct3 = ins[14:12];
   assign f7b5   = ins[30];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) run <= 1'b0;
      else          run <= 1'b1;
   end

   // SUB only exists for R-type; OP-IMM reuses f7b5 solely for SRAI.
   always_comb begin
      alu_f3 = ALU_ADD;
      case (funct3)
         3'b000:  alu_f3 = (opcode == OP_R && f7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_f3 = ALU_SLL;
         3'b010:  alu_f3 = ALU_SLT;
         3'b011:  alu_f3 = ALU_SLTU;
         3'b100:  alu_f3 = ALU_XOR;
         3'b101:  alu_f3 = f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  alu_f3 = ALU_OR;
         default: alu_f3 = ALU_AND;
      endcase
   end

   always_comb begin
      d_rd_wren  = 1'b0;
      d_vld      = 1'b1;
      d_br_un    = 1'b0;
      d_opa      = 1'b0;
      d_opb      = 1'b0;
      d_alu      = ALU_ADD;
      d_mem_wren = 1'b0;
      d_wb       = 2'b01;
      d_psel     = 1'b0;
      case (opcode)
         OP_R: begin
            d_rd_wren = 1'b1;
            d_alu     = alu_f3;
         end
         OP_IMM: begin
            d_rd_wren = 1'b1;
            d_opb     = 1'b1;
            d_alu     = alu_f3;
         end
         OP_LOAD: begin
            d_rd_wren = 1'b1;
            d_opb     = 1'b1;
            d_wb      = 2'b10;
         end
         OP_STORE: begin
            d_mem_wren = 1'b1;
            d_opb      = 1'b1;
         end
         OP_BRANCH: begin
            if (funct3 == 3'b010 || funct3 == 3'b011) begin
               d_vld = 1'b0;
            end else begin
               d_opa   = 1'b1;
               d_opb   = 1'b1;
               d_br_un = funct3[1];
               // funct3[2] picks less-than vs equality, funct3[0] inverts.
               d_psel  = (funct3[2] ? br_less : br_equal) ^ funct3[0];
            end
         end
         OP_JAL: begin
            d_rd_wren = 1'b1;
            d_opa     = 1'b1;
            d_opb     = 1'b1;
            d_wb      = 2'b00;
            d_psel    = 1'b1;
         end
         OP_JALR: begin
            d_rd_wren = 1'b1;
            d_opb     = 1'b1;
            d_wb      = 2'b00;
            d_psel    = 1'b1;
         end
         OP_LUI: begin
            d_rd_wren = 1'b1;
            d_opb     = 1'b1;
            d_alu     = ALU_PASSB;
         end
         OP_AUIPC: begin
            d_rd_wren = 1'b1;
            d_opa     = 1'b1;
            d_opb     = 1'b1;
         end
         default: d_vld = 1'b0;
      endcase
   end

   // Reset zeroes everything; the first cycle after reset only blocks side effects.
   assign rd_wren  = reset_n & run & d_rd_wren;
   assign isns_vld = reset_n & run & d_vld;
   assign mem_wren = reset_n & run & d_mem_wren;
   assign psel     = reset_n & run & d_psel;
   assign br_un    = reset_n & d_br_un;
   assign opa_sel  = reset_n & d_opa;
   assign opb_sel  = reset_n & d_opb;
   assign alu_op   = reset_n ? d_alu : 4'b0000;
   assign wb_sel   = reset_n ? d_wb  : 2'b00;

endmodule

// File: tb/tb_riscv_control_unit.sv
// Directed bench for riscv_control_unit: hand-computed decode vectors checked
// with immediate assertions.
`timescale 1ns/1ps
module tb_riscv_control_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] ins;
   logic        br_less, br_equal;
   logic        rd_wren, isns_vld, br_un, opa_sel, opb_sel, mem_wren, psel;
   logic [3:0]  alu_op;
   logic [1:0]  wb_sel;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   riscv_control_unit dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .ins      (ins),
      .br_less  (br_less),
      .br_equal (br_equal),
      .rd_wren  (rd_wren),
      .isns_vld (isns_vld),
      .br_un    (br_un),
      .opa_sel  (opa_sel),
      .opb_sel  (opb_sel),
      .alu_op   (alu_op),
      .mem_wren (mem_wren),
      .wb_sel   (wb_sel),
      .psel     (psel)
   );

   // Packed order: rd_wren, isns_vld, br_un, opa, opb, alu[3:0], mem_wren, wb[1:0], psel
   task automatic expect_all(input string tag,
                             input logic rd, input logic vld, input logic bru,
                             input logic opa, input logic opb, input logic [3:0] alu,
                             input logic mem, input logic [1:0] wb, input logic ps);
      logic [12:0] obs, exp;
      obs = {rd_wren, isns_vld, br_un, opa_sel, opb_sel, alu_op, mem_wren, wb_sel, psel};
      exp = {rd, vld, bru, opa, opb, alu, mem, wb, ps};
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic apply(input logic [31:0] i, input logic lt, input logic eq);
      @(negedge clk);
      ins = i; br_less = lt; br_equal = eq;
      #1;
   endtask

   initial begin
      reset_n = 1'b0; ins = 32'h001101B3; br_less = 1'b0; br_equal = 1'b0;
      #1;
      expect_all("reset_add", 0,0,0,0,0,4'b0000,0,2'b00,0);
      repeat (2) @(posedge clk);
      ins = 32'h000000EF; #1;
      expect_all("reset_jal", 0,0,0,0,0,4'b0000,0,2'b00,0);

      // Release at a negedge: decode visible, side effects gated
      @(negedge clk);
      reset_n = 1'b1; ins = 32'h401101B3; #1;
      expect_all("first_cycle_sub", 0,0,0,0,0,4'b0001,0,2'b01,0);
      @(posedge clk); #1;
      expect_all("running_sub", 1,1,0,0,0,4'b0001,0,2'b01,0);

      apply(32'h001101B3, 0, 0); expect_all("add",   1,1,0,0,0,4'b0000,0,2'b01,0);
      apply(32'h001121B3, 0, 0); expect_all("slt",   1,1,0,0,0,4'b0011,0,2'b01,0);
      apply(32'h401151B3, 0, 0); expect_all("sra",   1,1,0,0,0,4'b0111,0,2'b01,0);
      apply(32'h001171B3, 0, 0); expect_all("and",   1,1,0,0,0,4'b1001,0,2'b01,0);
      apply(32'h00510193, 0, 0); expect_all("addi",  1,1,0,0,1,4'b0000,0,2'b01,0);
      apply(32'h40510193, 0, 0); expect_all("addi_f7b5", 1,1,0,0,1,4'b0000,0,2'b01,0);
      apply(32'h00515193, 0, 0); expect_all("srli",  1,1,0,0,1,4'b0110,0,2'b01,0);
      apply(32'h40515193, 0, 0); expect_all("srai",  1,1,0,0,1,4'b0111,0,2'b01,0);
      apply(32'h00412183, 0, 0); expect_all("lw",    1,1,0,0,1,4'b0000,0,2'b10,0);
      apply(32'h003121A3, 0, 0); expect_all("sw",    0,1,0,0,1,4'b0000,1,2'b01,0);

      apply(32'h003101E3, 0, 0); expect_all("beq_ne",  0,1,0,1,1,4'b0000,0,2'b01,0);
      apply(32'h003101E3, 0, 1); expect_all("beq_eq",  0,1,0,1,1,4'b0000,0,2'b01,1);
      apply(32'h003111E3, 0, 1); expect_all("bne_eq",  0,1,0,1,1,4'b0000,0,2'b01,0);
      apply(32'h003111E3, 0, 0); expect_all("bne_ne",  0,1,0,1,1,4'b0000,0,2'b01,1);
      apply(32'h003161E3, 1, 0); expect_all("bltu_lt", 0,1,1,1,1,4'b0000,0,2'b01,1);
      apply(32'h003161E3, 0, 1); expect_all("bltu_ge", 0,1,1,1,1,4'b0000,0,2'b01,0);
      apply(32'h003151E3, 1, 0); expect_all("bge_lt",  0,1,0,1,1,4'b0000,0,2'b01,0);
      apply(32'h003151E3, 0, 0); expect_all("bge_ge",  0,1,0,1,1,4'b0000,0,2'b01,1);
      apply(32'h003171E3, 0, 0); expect_all("bgeu_ge", 0,1,1,1,1,4'b0000,0,2'b01,1);
      apply(32'h003121E3, 1, 1); expect_all("br_f3_010", 0,0,0,0,0,4'b0000,0,2'b01,0);

      apply(32'h000000EF, 0, 0); expect_all("jal",   1,1,0,1,1,4'b0000,0,2'b00,1);
      apply(32'h000000E7, 0, 0); expect_all("jalr",  1,1,0,0,1,4'b0000,0,2'b00,1);
      apply(32'h000000B7, 0, 0); expect_all("lui",   1,1,0,0,1,4'b1010,0,2'b01,0);
      apply(32'h00000097, 0, 0); expect_all("auipc", 1,1,0,1,1,4'b0000,0,2'b01,0);
      apply(32'h0000007F, 1, 1); expect_all("illegal", 0,0,0,0,0,4'b0000,0,2'b01,0);

      // Mid-run reset zeroes outputs at once; next release gates the first cycle again
      apply(32'h000000EF, 0, 0);
      reset_n = 1'b0; #1;
      expect_all("midrun_reset", 0,0,0,0,0,4'b0000,0,2'b00,0);
      @(negedge clk);
      reset_n = 1'b1; #1;
      expect_all("rerelease_jal", 0,0,0,1,1,4'b0000,0,2'b00,0);
      @(posedge clk); #1;
      expect_all("rerun_jal", 1,1,0,1,1,4'b0000,0,2'b00,1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_control_unit.md
Name: riscv_control_unit

Overview:
Main decoder for the single-cycle RV32I core. It takes the fetched instruction word and the branch comparator flags, and produces the datapath selects, the ALU operation, the register-file and memory write enables, the write-back select and the PC select. Decode is combinational. A one-bit run flag, clocked by clk and cleared by reset_n, gates every side-effecting output so that nothing is written during reset or in the first cycle after reset.

Parameters:
None. All encodings below are fixed.

Ports:
clk       in   1   system clock; rising edge updates the run flag only
reset_n   in   1   asynchronous, active-low reset
ins       in   32  current instruction word
br_less   in   1   comparator: rs1 < rs2 (signedness follows br_un)
br_equal  in   1   comparator: rs1 == rs2
rd_wren   out  1   register-file write enable
isns_vld  out  1   instruction valid (legal opcode and unit running)
br_un     out  1   1 = unsigned compare request to the comparator
opa_sel   out  1   ALU operand A: 0 = rs1, 1 = PC
opb_sel   out  1   ALU operand B: 0 = rs2, 1 = immediate
alu_op    out  4   ALU operation code
mem_wren  out  1   data-memory write enable
wb_sel    out  2   write-back source: 00 = PC+4, 01 = ALU, 10 = load data, 11 = reserved
psel      out  1   next PC: 0 = PC+4, 1 = ALU result

Behaviour:
- Field slicing: opcode = ins[6:0], funct3 = ins[14:12], f7b5 = ins[30].
- alu_op codes: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001, PASSB 1010. Codes 1011 to 1111 are never driven.
- ALU op from funct3: 000 ADD (SUB if R-type and f7b5=1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if f7b5=1), 110 OR, 111 AND.
- OP-IMM ignores f7b5 except for funct3=101, so ADDI never becomes SUB.
- Per-opcode outputs. Fields not listed are: rd_wren 0, mem_wren 0, opa 0, opb 0, wb 01, psel 0, alu ADD.
  - R 0110011: rd_wren 1, opb 0, alu from funct3/f7b5.
  - OP-IMM 0010011: rd_wren 1, opb 1, alu from funct3 (f7b5 only for 101).
  - LOAD 0000011: rd_wren 1, opb 1, ADD, wb 10.
  - STORE 0100011: mem_wren 1, opb 1, ADD.
  - BRANCH 1100011: opa 1, opb 1, ADD, br_un = funct3[1].
    - psel = br_equal (000 BEQ), !br_equal (001 BNE), br_less (100/110), !br_less (101/111).
    - funct3 010/011 are illegal.
  - JAL 1101111: rd_wren 1, opa 1, opb 1, ADD, wb 00, psel 1.
  - JALR 1100111: rd_wren 1, opa 0, opb 1, ADD, wb 00, psel 1.
  - LUI 0110111: rd_wren 1, opb 1, alu PASSB, wb 01.
  - AUIPC 0010111: rd_wren 1, opa 1, opb 1, ADD, wb 01.
- br_un is 0 for every non-branch opcode.
- Illegal instruction (any other opcode, or the illegal branch funct3): default field values, and isns_vld = 0.
- rd_wren is not masked for rd = x0; the register file ignores writes to x0.
- Run flag:
  - Asynchronously cleared while reset_n = 0.
  - Set at the first rising clk edge with reset_n = 1; stays set until the next reset.
- Gating while run flag = 0: rd_wren, mem_wren, psel and isns_vld are forced to 0. The other outputs still decode.
- While reset_n = 0, every output is 0, including alu_op 0000 and wb_sel 00, independent of ins.
- Outputs change combinationally with ins, br_less and br_equal once running (same-cycle response). A reset asserted mid-instruction immediately zeroes all outputs.

Test Plan:
- Reset held, ins = 0x001101B3 -> all outputs 0. Release reset, first posedge -> isns_vld 1.
- ins 0x001101B3 (ADD) -> rd_wren 1, alu_op 0000, wb_sel 01, opb_sel 0. With f7b5 = 1 (SUB) -> alu_op 0001.
- ins 0x00510193 (ADDI) -> rd_wren 1, opb_sel 1, alu_op 0000, wb_sel 01. ins 0x00412183 (LW) -> rd_wren 1, mem_wren 0, wb_sel 10.
- ins 0x003121A3 (SW) -> rd_wren 0, mem_wren 1, wb_sel 01. ins 0x003101E3 (BEQ) -> br_un 0, alu_op 0000, opa_sel 1, psel follows br_equal (0 then 1).
- BLTU (funct3 110) -> br_un 1, psel = br_less. BGE -> psel = !br_less.
- ins 0x000000EF (JAL) -> rd_wren 1, wb_sel 00, psel 1. ins 0x000000B7 (LUI) -> rd_wren 1, wb_sel 01, alu_op 1010. ins 0x0000007F (illegal) -> isns_vld 0, rd_wren 0, mem_wren 0, psel 0.
